// File: rtl/sram_bist_pkg.sv
// -----------------------------------------------------------------------------
// sram_bist_pkg
// Shared definitions for the SRAM March C- BIST controller:
//   - bist_state_t : FSM state encoding (IDLE, M0..M5, DONE)
//   - march_elem_t : one March element (address direction and its operations)
//   - march_elem() : the March C- element table, indexed by FSM state
//   - next_elem()  : element sequencing, M5 is followed by DONE
// -----------------------------------------------------------------------------
package sram_bist_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        M0   = 3'd1,
        M1   = 3'd2,
        M2   = 3'd3,
        M3   = 3'd4,
        M4   = 3'd5,
        M5   = 3'd6,
        DONE = 3'd7
    } bist_state_t;

    // Each element is an optional read followed by an optional write.
    // rd_val/wr_val select the data background: 0 = PATTERN, 1 = ~PATTERN.
    typedef struct packed {
        logic down;
        logic has_rd;
        logic rd_val;
        logic has_wr;
        logic wr_val;
    } march_elem_t;

    // Address direction on its own, so the controller can preload the
    // counter for the element it is about to enter.
    function automatic logic elem_down(input bist_state_t s);
        return (s == M3) || (s == M4);
    endfunction

    // March C-: M0 up(w0); M1 up(r0,w1); M2 up(r1,w0);
    //           M3 down(r0,w1); M4 down(r1,w0); M5 up(r0)
    function automatic march_elem_t march_elem(input bist_state_t s);
        march_elem_t e;
        e = '0;
        case (s)
            M0:      e = '{down: 1'b0, has_rd: 1'b0, rd_val: 1'b0, has_wr: 1'b1, wr_val: 1'b0};
            M1:      e = '{down: 1'b0, has_rd: 1'b1, rd_val: 1'b0, has_wr: 1'b1, wr_val: 1'b1};
            M2:      e = '{down: 1'b0, has_rd: 1'b1, rd_val: 1'b1, has_wr: 1'b1, wr_val: 1'b0};
            M3:      e = '{down: 1'b1, has_rd: 1'b1, rd_val: 1'b0, has_wr: 1'b1, wr_val: 1'b1};
            M4:      e = '{down: 1'b1, has_rd: 1'b1, rd_val: 1'b1, has_wr: 1'b1, wr_val: 1'b0};
            M5:      e = '{down: 1'b0, has_rd: 1'b1, rd_val: 1'b0, has_wr: 1'b0, wr_val: 1'b0};
            default: e = '0;
        endcase
        e.down = elem_down(s);
        return e;
    endfunction

    function automatic bist_state_t next_elem(input bist_state_t s);
        case (s)
            M0:      return M1;
            M1:      return M2;
            M2:      return M3;
            M3:      return M4;
            M4:      return M5;
            M5:      return DONE;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/sram_bist_cmp.sv
// -----------------------------------------------------------------------------
// sram_bist_cmp
// Read-compare pipeline. When a BIST read is issued, the expected data and
// address are registered at the same edge the SRAM samples the access; on the
// following cycle the returned data of both banks is compared against it.
//
// Ports:
//   hclk, hrstn        clock, asynchronous active-low reset
//   rd_en              a BIST read is being issued this cycle
//   rd_exp, rd_addr    expected data / address of that read
//   rdata0, rdata1     bank0 / bank1 read data (valid the cycle after the read)
//   mismatch[1:0]      per-bank miscompare, valid in the compare cycle
//   cmp_addr           address of the read being compared
// -----------------------------------------------------------------------------
module sram_bist_cmp
    import sram_bist_pkg::*;
#(
    parameter int ADDR_W = 13
) (
    input  logic              hclk,
    input  logic              hrstn,
    input  logic              rd_en,
    input  logic [31:0]       rd_exp,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rdata0,
    input  logic [31:0]       rdata1,
    output logic [1:0]        mismatch,
    output logic [ADDR_W-1:0] cmp_addr
);

    logic        cmp_vld;
    logic [31:0] exp_q;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            cmp_vld  <= 1'b0;
            exp_q    <= '0;
            cmp_addr <= '0;
        end else begin
            cmp_vld <= rd_en;
            if (rd_en) begin
                exp_q    <= rd_exp;
                cmp_addr <= rd_addr;
            end
        end
    end

    assign mismatch = cmp_vld ? {(rdata1 != exp_q), (rdata0 != exp_q)} : 2'b00;

endmodule

// File: rtl/sram_bist_ctrl.sv
// -----------------------------------------------------------------------------
// sram_bist_ctrl
// March C- BIST controller for two 32-bit SRAM banks tested in parallel, with a
// functional pass-through mux in front of the SRAM controls.
//
// Parameters:
//   ADDR_W   word-address width per bank (2**ADDR_W words)
//   PATTERN  data background "0"; ~PATTERN is background "1"
//
// Ports:
//   hclk, hrstn                       clock, asynchronous active-low reset
//   bist_start                        start request (ignored while busy)
//   func_bank0_csn, func_bank1_csn    functional byte-lane chip selects
//   func_we, func_addr, func_wdata    functional write enable/address/data
//   sram_rdata0, sram_rdata1          bank read data, one cycle after a read
//   bank0_csn, bank1_csn, sram_we,
//   sram_addr, sram_wdata             muxed SRAM controls
//   bist_busy, bist_done, bist_fail   run status
//   fail_bank, fail_addr              banks and address of the first miscompare
//
// Build option:
//   SRAM_BIST_STOP_ON_FAIL_EN  when defined, the run ends at the edge that
//                              registers the first miscompare.
// -----------------------------------------------------------------------------
module sram_bist_ctrl
    import sram_bist_pkg::*;
#(
    parameter int          ADDR_W  = 13,
    parameter logic [31:0] PATTERN = 32'h5555_AAAA
) (
    input  logic              hclk,
    input  logic              hrstn,
    input  logic              bist_start,
    input  logic [3:0]        func_bank0_csn,
    input  logic [3:0]        func_bank1_csn,
    input  logic              func_we,
    input  logic [ADDR_W-1:0] func_addr,
    input  logic [31:0]       func_wdata,
    input  logic [31:0]       sram_rdata0,
    input  logic [31:0]       sram_rdata1,
    output logic [3:0]        bank0_csn,
    output logic [3:0]        bank1_csn,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    output logic              bist_busy,
    output logic              bist_done,
    output logic              bist_fail,
    output logic [1:0]        fail_bank,
    output logic [ADDR_W-1:0] fail_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    bist_state_t       state;
    logic [ADDR_W-1:0] addr_cnt;
    logic              phase;   // 0: first op of a two-op element, 1: its write
    logic              drain;   // M5 reads done, waiting for the final compare

    march_elem_t       elem;
    logic              access;
    logic              op_rd;
    logic              op_wr;
    logic              last_op;
    logic              at_end;
    logic [1:0]        cmp_mismatch;
    logic [ADDR_W-1:0] cmp_addr;
    logic              abort;

    assign elem    = march_elem(state);
    assign access  = bist_busy & ~drain;
    assign op_rd   = access & elem.has_rd & ~phase;
    assign op_wr   = access & elem.has_wr & (phase | ~elem.has_rd);
    assign last_op = ~elem.has_rd | ~elem.has_wr | phase;
    assign at_end  = elem.down ? (addr_cnt == '0) : (addr_cnt == LAST_ADDR);

`ifdef SRAM_BIST_STOP_ON_FAIL_EN
    assign abort = |cmp_mismatch;
`else
    assign abort = 1'b0;
`endif

    // The mux select is a reset-cleared register, so reset returns the SRAM
    // to functional control immediately, even mid-test.
    // NOTE: every output gets a value on every path through this block, so no
    // latch can be inferred.
    always_comb begin
        bank0_csn  = func_bank0_csn;
        bank1_csn  = func_bank1_csn;
        sram_we    = func_we;
        sram_addr  = func_addr;
        sram_wdata = func_wdata;
        if (bist_busy) begin
            bank0_csn  = access ? 4'b0000 : 4'b1111;
            bank1_csn  = access ? 4'b0000 : 4'b1111;
            sram_we    = op_wr;
            sram_addr  = addr_cnt;
            sram_wdata = elem.wr_val ? ~PATTERN : PATTERN;
        end
    end

    sram_bist_cmp #(
        .ADDR_W (ADDR_W)
    ) u_cmp (
        .hclk     (hclk),
        .hrstn    (hrstn),
        .rd_en    (op_rd),
        .rd_exp   (elem.rd_val ? ~PATTERN : PATTERN),
        .rd_addr  (addr_cnt),
        .rdata0   (sram_rdata0),
        .rdata1   (sram_rdata1),
        .mismatch (cmp_mismatch),
        .cmp_addr (cmp_addr)
    );

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            state     <= IDLE;
            addr_cnt  <= '0;
            phase     <= 1'b0;
            drain     <= 1'b0;
            bist_busy <= 1'b0;
            bist_done <= 1'b0;
            bist_fail <= 1'b0;
            fail_bank <= 2'b00;
            fail_addr <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bist_start) begin
                        state     <= M0;
                        addr_cnt  <= '0;
                        phase     <= 1'b0;
                        drain     <= 1'b0;
                        bist_busy <= 1'b1;
                        bist_done <= 1'b0;
                        bist_fail <= 1'b0;
                        fail_bank <= 2'b00;
                        fail_addr <= '0;
                    end
                end
                default: begin
                    // Only the first miscompare of a run is localised.
                    if (|cmp_mismatch) begin
                        bist_fail <= 1'b1;
                        if (!bist_fail) begin
                            fail_bank <= cmp_mismatch;
                            fail_addr <= cmp_addr;
                        end
                    end

                    if (drain || abort) begin
                        state     <= DONE;
                        drain     <= 1'b0;
                        phase     <= 1'b0;
                        bist_busy <= 1'b0;
                        bist_done <= 1'b1;
                    end else if (!last_op) begin
                        phase <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        if (!at_end) begin
                            addr_cnt <= elem.down ? addr_cnt - 1'b1 : addr_cnt + 1'b1;
                        end else if (state == M5) begin
                            // The last read's data still has to be compared.
                            drain <= 1'b1;
                        end else begin
                            state    <= next_elem(state);
                            addr_cnt <= elem_down(next_elem(state)) ? LAST_ADDR : '0;
                        end
                    end
                end
            endcase
        end
    end

endmodule
